// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
//
// Purpose:
//   Generates a set of staged, active-low reset outputs for the downstream
//   clock domain. Releases start only after the external reset request (and,
//   optionally, the clock-source lock) has been stable for a debounce window.
//   Stage 0 is released first, and each further stage follows P_DELAY cycles
//   later. RESET_DONE rises P_DELAY cycles after the last stage is released.
//   If the qualification is lost at any point, every output drops at once and
//   the whole sequence starts again from HOLD.
//
// Parameters:
//   P_STAGES   - number of staged reset outputs (1..16)
//   P_DELAY    - clock cycles between consecutive stage releases (>= 1)
//   P_DEBOUNCE - consecutive qualified cycles needed before the first release
//
// Ports:
//   CLOCK      in   sole clock; all state changes on its rising edge
//   RESET_N    in   asynchronous active-low reset (power-on reset)
//   EXT_RST_N  in   external board reset request, asynchronous, active-low
//   LOCKED     in   PLL lock indication, asynchronous, active-high
//                   (only present when RST_SEQ_LOCK_WAIT_EN is defined)
//   RST_OUT_N  out  staged active-low resets; bit 0 is released first
//   RESET_DONE out  high once every stage is released and the settle time
//                   has elapsed
//
// Configuration macro:
//   RST_SEQ_LOCK_WAIT_EN - when defined, the LOCKED port and its synchronizer
//                          exist and the lock gates the qualification. When
//                          undefined, the lock is treated as permanently
//                          asserted and the timing is otherwise identical.
// -----------------------------------------------------------------------------
module reset_sequencer #(
   parameter int unsigned P_STAGES   = 4,
   parameter int unsigned P_DELAY    = 16,
   parameter int unsigned P_DEBOUNCE = 8
) (
   input  logic                CLOCK,
   input  logic                RESET_N,
   input  logic                EXT_RST_N,
`ifdef RST_SEQ_LOCK_WAIT_EN
   input  logic                LOCKED,
`endif
   output logic [P_STAGES-1:0] RST_OUT_N,
   output logic                RESET_DONE
);

   // The counter must hold P-1 for the longer of the two intervals. The
   // extra bit guarantees that the counter never wraps.
   localparam int unsigned CNT_MAX = (P_DELAY > P_DEBOUNCE) ? P_DELAY : P_DEBOUNCE;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

   localparam logic [CNT_W-1:0]    DEB_LAST  = CNT_W'(P_DEBOUNCE - 1);
   localparam logic [CNT_W-1:0]    DLY_LAST  = CNT_W'(P_DELAY - 1);
   localparam logic [P_STAGES-1:0] STAGE_ONE = P_STAGES'(1);

   typedef enum logic [1:0] {
      ST_HOLD     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_RELEASE  = 2'd2,
      ST_DONE     = 2'd3
   } state_e;

   // ---------------------------------------------------------------------------
   // Input synchronizers
   // ---------------------------------------------------------------------------
   logic ext_meta_q;
   logic ext_s_q;
   logic lock_s;
   logic qual;

   // NOTE: the synchronizer flops reset to 0 so that the request reads as
   // "still in reset" until a clean value has passed through both stages.
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         ext_meta_q <= 1'b0;
         ext_s_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make both flops sample on the same
         // edge, so the chain really is two stages deep.
         ext_meta_q <= EXT_RST_N;
         ext_s_q    <= ext_meta_q;
      end
   end

`ifdef RST_SEQ_LOCK_WAIT_EN
   logic lock_meta_q;
   logic lock_s_q;

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         lock_meta_q <= 1'b0;
         lock_s_q    <= 1'b0;
      end else begin
         lock_meta_q <= LOCKED;
         lock_s_q    <= lock_meta_q;
      end
   end

   assign lock_s = lock_s_q;
`else
   assign lock_s = 1'b1;
`endif

   assign qual = ext_s_q & lock_s;

   // ---------------------------------------------------------------------------
   // Sequencing state machine
   // ---------------------------------------------------------------------------
   state_e              state_q,   state_d;
   logic [CNT_W-1:0]    cnt_q,     cnt_d;
   logic [P_STAGES-1:0] rst_out_q, rst_out_d;
   logic                done_q,    done_d;

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q   <= ST_HOLD;
         cnt_q     <= '0;
         rst_out_q <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rst_out_q <= rst_out_d;
         done_q    <= done_d;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first. As a result,
      // no branch can leave a signal unassigned, and no latch is inferred.
      state_d   = state_q;
      cnt_d     = cnt_q;
      rst_out_d = rst_out_q;
      done_d    = done_q;

      if (!qual) begin
         // A lost qualification wins over any pending release or completion.
         // It also acts as the idle behaviour of HOLD.
         state_d   = ST_HOLD;
         cnt_d     = '0;
         rst_out_d = '0;
         done_d    = 1'b0;
      end else begin
         unique case (state_q)
            ST_HOLD: begin
               state_d = ST_DEBOUNCE;
               cnt_d   = '0;
            end

            ST_DEBOUNCE: begin
               if (cnt_q == DEB_LAST) begin
                  state_d   = ST_RELEASE;
                  cnt_d     = '0;
                  rst_out_d = STAGE_ONE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end

            ST_RELEASE: begin
               if (cnt_q == DLY_LAST) begin
                  cnt_d = '0;
                  // Released bits form a contiguous run from bit 0. When the
                  // top bit is set, every stage is out and only the settle
                  // interval remains.
                  if (rst_out_q[P_STAGES-1]) begin
                     state_d = ST_DONE;
                     done_d  = 1'b1;
                  end else begin
                     rst_out_d = (rst_out_q << 1) | STAGE_ONE;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end

            ST_DONE: begin
               state_d = ST_DONE;
            end

            default: begin
               state_d   = ST_HOLD;
               cnt_d     = '0;
               rst_out_d = '0;
               done_d    = 1'b0;
            end
         endcase
      end
   end

   // Outputs come straight from flops. There is no combinational path from
   // any input to these outputs.
   assign RST_OUT_N  = rst_out_q;
   assign RESET_DONE = done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reset_sequencer
//
// Testbench for reset_sequencer. The main instance uses the default
// parameters. A second, minimal instance (2 stages, delay 1, debounce 1)
// exercises the single-cycle boundaries. Both instances share the same
// inputs.
//
// Expected output values are pushed into a scoreboard queue, each tagged
// with the cycle number at which it must appear. Cycle 1 is the first
// rising edge after RESET_N is released. The queue is popped and compared
// one time unit after each rising edge.
//
// The lock-loss scenario exists only when RST_SEQ_LOCK_WAIT_EN is defined.
// -----------------------------------------------------------------------------
module tb_reset_sequencer;

   logic       CLOCK     = 1'b0;
   logic       RESET_N   = 1'b0;
   logic       EXT_RST_N = 1'b1;
`ifdef RST_SEQ_LOCK_WAIT_EN
   logic       LOCKED    = 1'b1;
`endif
   logic [3:0] rst_out;
   logic       done;
   logic [1:0] min_rst;
   logic       min_done;

   reset_sequencer #(
      .P_STAGES  (4),
      .P_DELAY   (16),
      .P_DEBOUNCE(8)
   ) u_dut (
      .CLOCK     (CLOCK),
      .RESET_N   (RESET_N),
      .EXT_RST_N (EXT_RST_N),
`ifdef RST_SEQ_LOCK_WAIT_EN
      .LOCKED    (LOCKED),
`endif
      .RST_OUT_N (rst_out),
      .RESET_DONE(done)
   );

   reset_sequencer #(
      .P_STAGES  (2),
      .P_DELAY   (1),
      .P_DEBOUNCE(1)
   ) u_min (
      .CLOCK     (CLOCK),
      .RESET_N   (RESET_N),
      .EXT_RST_N (EXT_RST_N),
`ifdef RST_SEQ_LOCK_WAIT_EN
      .LOCKED    (LOCKED),
`endif
      .RST_OUT_N (min_rst),
      .RESET_DONE(min_done)
   );

   always #5 CLOCK = ~CLOCK;

   typedef struct {
      int         cyc;
      bit         is_min;
      logic [4:0] exp;
      string      tag;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Observed value packed as {RESET_DONE, RST_OUT_N}.
   function automatic logic [4:0] obs_of(input bit is_min);
      return is_min ? {2'b00, min_done, min_rst} : {done, rst_out};
   endfunction

   task automatic push(input int c, input bit is_min, input logic [4:0] e, input string tag);
      exp_t x;
      x.cyc    = c;
      x.is_min = is_min;
      x.exp    = e;
      x.tag    = tag;
      sb.push_back(x);
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge CLOCK);
         #1;
         cyc++;
         while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            check($sformatf("%s@E%0d", e.tag, e.cyc), 32'(obs_of(e.is_min)), 32'(e.exp));
         end
      end
   endtask

   // Every expectation must have been reached by the end of a scenario.
   task automatic drain(input string tag);
      check({tag, "_pending"}, 32'(sb.size()), 32'd0);
      sb.delete();
   endtask

   // Holds reset across one edge, then releases it between edges. The next
   // rising edge becomes E1.
   task automatic restart();
      RESET_N = 1'b0;
      @(posedge CLOCK);
      #1;
      EXT_RST_N = 1'b1;
`ifdef RST_SEQ_LOCK_WAIT_EN
      LOCKED    = 1'b1;
`endif
      RESET_N = 1'b1;
      cyc     = 0;
   endtask

   // Nominal timing: stage k rises at E(11+16k), and DONE rises at E75.
   task automatic push_nominal(input string tag);
      logic [3:0] prev;
      logic [3:0] next;
      for (int k = 0; k < 4; k++) begin
         prev = 4'((1 << k) - 1);
         next = 4'((1 << (k + 1)) - 1);
         push(10 + 16 * k, 1'b0, {1'b0, prev}, {tag, "_pre"});
         push(11 + 16 * k, 1'b0, {1'b0, next}, {tag, "_rise"});
      end
      push(74, 1'b0, 5'h0F, {tag, "_settle"});
      push(75, 1'b0, 5'h1F, {tag, "_done"});
   endtask

   initial begin
      // Reset state, before any clock edge.
      #2;
      check("reset_main", 32'({done, rst_out}), 32'h0);
      check("reset_min", 32'({min_done, min_rst}), 32'h0);

      // Nominal sequence, plus the minimal-parameter boundary instance.
      restart();
      push(3, 1'b1, 5'h00, "min_hold");
      push(4, 1'b1, 5'h01, "min_stage0");
      push(5, 1'b1, 5'h03, "min_stage1");
      push(6, 1'b1, 5'h07, "min_done");
      push_nominal("nom");
      step(80);
      drain("nom");

      // Asynchronous reset in DONE, applied between edges.
      @(posedge CLOCK);
      #3;
      RESET_N = 1'b0;
      #1;
      check("async_rst_main", 32'({done, rst_out}), 32'h0);
      check("async_rst_min", 32'({min_done, min_rst}), 32'h0);
      restart();
      push_nominal("after_async");
      step(80);
      drain("after_async");

      // One-cycle glitch on EXT_RST_N during DEBOUNCE (sampled at E5).
      restart();
      step(4);
      EXT_RST_N = 1'b0;
      step(1);
      EXT_RST_N = 1'b1;
      push(11, 1'b0, 5'h00, "glitch_no_nominal");
      push(15, 1'b0, 5'h00, "glitch_pre");
      push(16, 1'b0, 5'h01, "glitch_s0");
      push(32, 1'b0, 5'h03, "glitch_s1");
      push(48, 1'b0, 5'h07, "glitch_s2");
      push(64, 1'b0, 5'h0F, "glitch_s3");
      push(79, 1'b0, 5'h0F, "glitch_settle");
      push(80, 1'b0, 5'h1F, "glitch_done");
      step(80);
      drain("glitch");

      // Priority: qual=0 is seen on the same edge as the stage-2 release (E43).
      restart();
      step(40);
      EXT_RST_N = 1'b0;
      push(42, 1'b0, 5'h03, "prio_pre");
      push(43, 1'b0, 5'h00, "prio_abort");
      push(50, 1'b0, 5'h00, "prio_held");
      push(60, 1'b0, 5'h00, "prio_rerun_pre");
      push(61, 1'b0, 5'h01, "prio_rerun_s0");
      step(10);
      EXT_RST_N = 1'b1;
      step(12);
      drain("prio");

`ifdef RST_SEQ_LOCK_WAIT_EN
      // Lock loss while RST_OUT_N=0x7, followed by a full rerun.
      restart();
      push(43, 1'b0, 5'h07, "lock_s2");
      step(45);
      LOCKED = 1'b0;
      push(47, 1'b0, 5'h07, "lock_still");
      push(48, 1'b0, 5'h00, "lock_abort");
      push(50, 1'b0, 5'h00, "lock_held");
      push(60, 1'b0, 5'h00, "lock_rerun_pre");
      push(61, 1'b0, 5'h01, "lock_rerun_s0");
      push(77, 1'b0, 5'h03, "lock_rerun_s1");
      push(93, 1'b0, 5'h07, "lock_rerun_s2");
      push(109, 1'b0, 5'h0F, "lock_rerun_s3");
      push(124, 1'b0, 5'h0F, "lock_rerun_settle");
      push(125, 1'b0, 5'h1F, "lock_rerun_done");
      step(5);
      LOCKED = 1'b1;
      step(77);
      drain("lock");
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 P_STAGES, default 4, number of staged reset outputs; legal range 1..16.
REQ-002 P_DELAY, default 16, clock cycles between consecutive stage releases; legal range >= 1.
REQ-003 P_DEBOUNCE, default 8, consecutive qualified cycles required before the first release; legal range >= 1.
REQ-004 CLOCK  input  1  sole clock; all state is on its rising edge.
REQ-005 RESET_N  input  1  asynchronous, active-low reset, normally driven by the power-on reset pulse generator.
REQ-006 EXT_RST_N  input  1  external board reset request, asynchronous to CLOCK, active-low.
REQ-007 LOCKED  input  1  PLL/clock-source lock indication, asynchronous to CLOCK, active-high; present only per REQ-027.
REQ-008 RST_OUT_N  output  P_STAGES  staged active-low resets; bit 0 is released first.
REQ-009 RESET_DONE  output  1  high once every stage is released and the settle time has elapsed.

Function
REQ-010 EXT_RST_N and LOCKED SHALL each pass through a 2-flop synchronizer before use; the synchronized values are ext_s and lock_s.
REQ-011 qual SHALL be ext_s AND lock_s.
REQ-012 The state machine SHALL have four states: HOLD, DEBOUNCE, RELEASE and DONE.
REQ-013 HOLD: all RST_OUT_N low and RESET_DONE low; the machine goes to DEBOUNCE with the counter at 0 on the first edge at which qual=1.
REQ-014 DEBOUNCE: the counter increments each cycle while qual=1; on the edge where the counter equals P_DEBOUNCE-1, the machine goes to RELEASE, sets RST_OUT_N[0]=1 and clears the counter (exactly P_DEBOUNCE cycles are spent in DEBOUNCE).
REQ-015 RELEASE: every P_DELAY cycles the next higher RST_OUT_N bit SHALL be set to 1.
REQ-016 Released bits SHALL stay at 1, and bits SHALL release strictly in ascending order.
REQ-017 Stage k SHALL release exactly k*P_DELAY edges after stage 0.
REQ-018 P_DELAY edges after the release of stage P_STAGES-1, the machine SHALL go to DONE and set RESET_DONE=1.
REQ-019 In DEBOUNCE, RELEASE or DONE, any edge that samples qual=0 SHALL move the machine to HOLD, drive all RST_OUT_N and RESET_DONE low on that same edge, and clear the counter.
REQ-020 When qual=0 is sampled in the same cycle as a pending release or DONE transition, qual=0 SHALL take priority and no release SHALL occur.
REQ-021 With P_STAGES=1, RESET_DONE SHALL assert P_DELAY edges after the release of RST_OUT_N[0].
REQ-022 With P_DELAY=1, stages SHALL release on consecutive edges.
REQ-023 The counter width SHALL be clog2 of the larger of P_DELAY and P_DEBOUNCE, plus 1; the counter SHALL never wrap.
REQ-024 All outputs SHALL be driven directly from flops, with no combinational path from any input.

Reset
REQ-025 When RESET_N=0, the block SHALL immediately and asynchronously enter HOLD with RST_OUT_N all 0, RESET_DONE=0, counter=0 and both synchronizers at 0.
REQ-026 If RESET_N asserts mid-sequence, the sequence SHALL abort; after RESET_N deasserts, the block SHALL restart from HOLD with the full debounce.

Configuration
REQ-027 The macro RST_SEQ_LOCK_WAIT_EN SHALL control the lock qualification:
- Defined: the LOCKED port and its synchronizer SHALL exist, and lock_s SHALL gate qual.
- Undefined: the LOCKED port SHALL be absent, lock_s SHALL be the constant 1, and the timing is otherwise identical.

Verification (P_STAGES=4, P_DELAY=16, P_DEBOUNCE=8, macro defined)
REQ-028 Nominal: EXT_RST_N=1 and LOCKED=1, then RESET_N is released before edge E1 -> RST_OUT_N[k] rises at E(11+16k) (values 0x1, 0x3, 0x7, 0xF at E11, E27, E43, E59), and RESET_DONE rises at E75.
REQ-029 Debounce glitch: EXT_RST_N is pulled low for one cycle during DEBOUNCE -> return to HOLD; the first release occurs 8+3 edges after the glitch ends, and RST_OUT_N stays 0x0 until then.
REQ-030 Lock loss: LOCKED falls while RST_OUT_N=0x7 -> RST_OUT_N becomes 0x0 on the 3rd edge after the fall; RESET_DONE stays 0; the full sequence reruns after LOCKED returns.
REQ-031 Async reset: RESET_N is pulsed low in DONE, between clock edges -> RST_OUT_N becomes 0x0 and RESET_DONE becomes 0 with no clock edge; after release the nominal timing of REQ-028 repeats.
REQ-032 Priority: EXT_RST_N=0 is synchronized on the same edge as the stage-2 release -> RST_OUT_N goes from 0x3 to 0x0; 0x7 is never observed.
REQ-033 Macro undefined: the nominal scenario with no LOCKED port -> the timing is identical to REQ-028.
